// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 widths and FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a loaded word and sign/zero-extends it.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  width,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select followed by extension according to funct3.
  always_comb begin
    byte_v = 8'(word >> {offset, 3'b000});
    half_v = offset[1] ? word[31:16] : word[15:0];
    result = '0;
    case (width)
      F3_B:    result = {{24{byte_v[7]}}, byte_v};
      F3_H:    result = {{16{half_v[15]}}, half_v};
      F3_W:    result = word;
      F3_BU:   result = {24'd0, byte_v};
      F3_HU:   result = {16'd0, half_v};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Single-outstanding load/store memory with byte enables and configurable load latency.
module lsu_mem
  import mem_pkg::*;
#(
  parameter int unsigned N   = 12,
  parameter int unsigned LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_width,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int unsigned DEPTH     = 2 ** N;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned WAIT_INIT = (LAT > 1) ? LAT - 2 : 0;

  state_e             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [31:0]        mem [DEPTH];
  logic [31:0]        rd_word;
  logic [1:0]         off_q;
  logic [2:0]         width_q;
  logic               load_q;
  logic               rsp_valid_q;
  logic               err_q;
  logic [31:0]        load_result;

  logic               accept;
  logic               err_c;
  logic               we_c;
  logic [3:0]         be_c;
  logic [31:0]        wlane_c;
  logic [N-1:0]       idx;
  logic               unused_addr_bits;

  assign o_req_ready      = (state == ST_IDLE) && !i_rst;
  assign accept           = i_req_valid && o_req_ready;
  assign idx              = i_addr[N+1:2];
  assign unused_addr_bits = ^i_addr[31:N+2];
  assign we_c             = accept && i_we && !err_c;

  // Misalignment and illegal-width detection for the incoming request.
  always_comb begin
    err_c = 1'b0;
    case (i_width)
      F3_B, F3_BU: err_c = 1'b0;
      F3_H, F3_HU: err_c = i_addr[0];
      F3_W:        err_c = |i_addr[1:0];
      default:     err_c = 1'b1;
    endcase
    if (i_we && (i_width == F3_BU || i_width == F3_HU)) err_c = 1'b1;
  end

  // Byte enables and replicated store data so every enabled lane sees its bytes.
  always_comb begin
    be_c    = 4'b0000;
    wlane_c = i_wdata;
    case (i_width)
      F3_B: begin
        be_c    = 4'(4'b0001 << i_addr[1:0]);
        wlane_c = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        be_c    = i_addr[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{i_wdata[15:0]}};
      end
      F3_W:    be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[idx][8*b +: 8] <= wlane_c[8*b +: 8];
      end
    end
  end

  // Registered read port captured at load acceptance.
  always_ff @(posedge i_clk) begin
    if (accept && !i_we) rd_word <= mem[idx];
  end

  // Request/response FSM with load latency counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      load_q      <= 1'b0;
      off_q       <= '0;
      width_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            off_q   <= i_addr[1:0];
            width_q <= i_width;
            err_q   <= err_c;
            load_q  <= !i_we && !err_c;
            if (i_we || err_c || LAT <= 1) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= CNT_W'(WAIT_INIT);
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  lsu_load_align u_align (
    .word   (rd_word),
    .offset (off_q),
    .width  (width_q),
    .result (load_result)
  );

  assign o_rsp_valid = rsp_valid_q;
  assign o_err       = err_q;
  assign o_rdata     = load_q ? load_result : 32'd0;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench: instance 0 uses LAT=1, instance 1 uses LAT=4.
module tb_lsu_mem;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        we        [2];
  logic [31:0] addr      [2];
  logic [2:0]  width     [2];
  logic [31:0] wdata     [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rdata     [2];
  logic        err       [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_mem #(.N(12), .LAT(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_we(we[0]), .i_addr(addr[0]), .i_width(width[0]), .i_wdata(wdata[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rdata(rdata[0]), .o_err(err[0])
  );

  lsu_mem #(.N(12), .LAT(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_we(we[1]), .i_addr(addr[1]), .i_width(width[1]), .i_wdata(wdata[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rdata(rdata[1]), .o_err(err[1])
  );

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request, wait for acceptance, then count cycles until the response shows up.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [2:0] f,
                       input logic [31:0] wd, input string tag, output int lat);
    int guard;
    @(negedge clk);
    we[d] = w; addr[d] = a; width[d] = f; wdata[d] = wd; req_valid[d] = 1'b1;
    guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check32({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_rsp(input int d);
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [2:0] f,
                     input logic [31:0] wd, input string tag, input logic [31:0] exp_data,
                     input logic exp_err, input int exp_lat);
    int lat;
    issue(d, w, a, f, wd, tag, lat);
    check32({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check32({tag, "_data"}, rdata[d], exp_data);
    check32({tag, "_err"}, 32'(err[d]), 32'(exp_err));
    finish_rsp(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic seen;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; we[d] = 1'b0; addr[d] = '0;
      width[d] = F3_W; wdata[d] = '0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check32("rst_valid", 32'(rsp_valid[0]), 32'd0);
    check32("rst_rdata", rdata[0], 32'd0);
    check32("rst_err", 32'(err[0]), 32'd0);
    check32("rst_ready_low", 32'(req_ready[0]), 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    check32("rst_ready_high", 32'(req_ready[0]), 32'd1);

    // Byte/half extraction and extension
    txn(0, 1'b1, 32'h10, F3_W,  32'h80FF7F01, "sw10",   32'h0,        1'b0, 1);
    txn(0, 1'b0, 32'h10, F3_B,  32'h0,        "lb10",   32'h00000001, 1'b0, 1);
    txn(0, 1'b0, 32'h13, F3_B,  32'h0,        "lb13",   32'hFFFFFF80, 1'b0, 1);
    txn(0, 1'b0, 32'h13, F3_BU, 32'h0,        "lbu13",  32'h00000080, 1'b0, 1);
    txn(0, 1'b0, 32'h12, F3_H,  32'h0,        "lh12",   32'hFFFF80FF, 1'b0, 1);
    txn(0, 1'b0, 32'h12, F3_HU, 32'h0,        "lhu12",  32'h000080FF, 1'b0, 1);
    txn(0, 1'b0, 32'h11, F3_B,  32'h0,        "lb11",   32'h0000007F, 1'b0, 1);

    // Partial stores merge into the existing word
    txn(0, 1'b1, 32'h20, F3_W,  32'h00000000, "sw20",   32'h0,        1'b0, 1);
    txn(0, 1'b1, 32'h21, F3_B,  32'hFFFFFFAA, "sb21",   32'h0,        1'b0, 1);
    txn(0, 1'b0, 32'h20, F3_W,  32'h0,        "lw20a",  32'h0000AA00, 1'b0, 1);
    txn(0, 1'b1, 32'h22, F3_H,  32'h1234BEEF, "sh22",   32'h0,        1'b0, 1);
    txn(0, 1'b0, 32'h20, F3_W,  32'h0,        "lw20b",  32'hBEEFAA00, 1'b0, 1);
    txn(0, 1'b0, 32'h22, F3_H,  32'h0,        "lh22",   32'hFFFFBEEF, 1'b0, 1);

    // Error requests leave memory untouched
    txn(0, 1'b1, 32'h04, F3_W,  32'h11223344, "sw04",   32'h0,        1'b0, 1);
    txn(0, 1'b0, 32'h06, F3_W,  32'h0,        "lw06",   32'h0,        1'b1, 1);
    txn(0, 1'b1, 32'h03, F3_H,  32'h0000FFFF, "sh03",   32'h0,        1'b1, 1);
    txn(0, 1'b1, 32'h04, F3_BU, 32'h000000FF, "sbu04",  32'h0,        1'b1, 1);
    txn(0, 1'b0, 32'h04, 3'd3,  32'h0,        "lf3",    32'h0,        1'b1, 1);
    txn(0, 1'b0, 32'h04, F3_W,  32'h0,        "lw04",   32'h11223344, 1'b0, 1);
    txn(0, 1'b0, 32'h05, F3_B,  32'h0,        "lb05",   32'h00000033, 1'b0, 1);

    // Store attempted while reset is held must not land
    @(negedge clk);
    rst[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h04; width[0] = F3_W;
    wdata[0] = 32'hDEADBEEF; req_valid[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_noaccept", 32'(req_ready[0]), 32'd0);
    req_valid[0] = 1'b0; rst[0] = 1'b0;
    txn(0, 1'b0, 32'h04, F3_W,  32'h0,        "lw04r",  32'h11223344, 1'b0, 1);

    // Address wrap above N+1
    txn(0, 1'b1, 32'h4010, F3_W, 32'hCAFEF00D, "sw4010", 32'h0,       1'b0, 1);
    txn(0, 1'b0, 32'h0010, F3_W, 32'h0,        "lw0010", 32'hCAFEF00D, 1'b0, 1);

    // Ready stays low in RESP and rises only after the handshake
    issue(0, 1'b0, 32'h10, F3_W, 32'h0, "hs", lat);
    check32("hs_ready_resp", 32'(req_ready[0]), 32'd0);
    finish_rsp(0);
    check32("hs_valid_after", 32'(rsp_valid[0]), 32'd0);
    check32("hs_ready_after", 32'(req_ready[0]), 32'd1);

    // LAT=4 timing and response hold under backpressure
    txn(1, 1'b1, 32'h30, F3_W, 32'h5A5AA5A5, "l4_sw", 32'h0, 1'b0, 1);
    txn(1, 1'b0, 32'h31, F3_W, 32'h0,        "l4_err", 32'h0, 1'b1, 1);
    issue(1, 1'b0, 32'h30, F3_W, 32'h0, "l4_lw", lat);
    check32("l4_lat", 32'(lat), 32'd4);
    check32("l4_data", rdata[1], 32'h5A5AA5A5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check32("l4_hold_valid", 32'(rsp_valid[1]), 32'd1);
      check32("l4_hold_data", rdata[1], 32'h5A5AA5A5);
      check32("l4_hold_err", 32'(err[1]), 32'd0);
      check32("l4_hold_ready", 32'(req_ready[1]), 32'd0);
    end
    finish_rsp(1);
    check32("l4_done_valid", 32'(rsp_valid[1]), 32'd0);

    // Reset during WAIT drops the pending load
    @(negedge clk);
    we[1] = 1'b0; addr[1] = 32'h30; width[1] = F3_W; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check32("rw_wait_valid", 32'(rsp_valid[1]), 32'd0);
    check32("rw_wait_ready", 32'(req_ready[1]), 32'd0);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    check32("rw_rst_valid", 32'(rsp_valid[1]), 32'd0);
    check32("rw_rst_rdata", rdata[1], 32'd0);
    rst[1] = 1'b0;
    #1;
    check32("rw_ready", 32'(req_ready[1]), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid[1];
    end
    check32("rw_no_stale", 32'(seen), 32'd0);
    txn(1, 1'b0, 32'h30, F3_W, 32'h0, "rw_reload", 32'h5A5AA5A5, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have parameter N, default 12, log2 of depth in 32-bit words (storage 4*2^N bytes).
REQ-002 SHALL have parameter LAT, default 1, load latency in cycles, legal 1..8.
REQ-003 SHALL have port i_clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_req_valid  input  1  request present.
REQ-006 SHALL have port o_req_ready  output  1  request accepted this cycle when high with i_req_valid.
REQ-007 SHALL have port i_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port i_addr  input  32  byte address; bits above N+1 ignored (wrap).
REQ-009 SHALL have port i_width  input  3  RV32 funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-010 SHALL have port i_wdata  input  32  store data, low-aligned.
REQ-011 SHALL have port o_rsp_valid  output  1  response present.
REQ-012 SHALL have port i_rsp_ready  input  1  response consumed when high with o_rsp_valid.
REQ-013 SHALL have port o_rdata  output  32  load result, extended; 0 for store/error responses.
REQ-014 SHALL have port o_err  output  1  misaligned or illegal-width request.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; o_req_ready = (state==IDLE) && !i_rst.
REQ-016 SHALL accept on cycle T when i_req_valid && o_req_ready; at most one request outstanding.
REQ-017 SHALL flag error when: width H/HU and addr[0]=1; width W and addr[1:0]!=0; width 3/6/7; or i_we with width 4/5.
REQ-018 SHALL, on accepted store without error, write at edge ending T: B -> lane addr[1:0]; H -> lanes {addr[1],0} and {addr[1],1}; W -> all four lanes; other lanes unchanged.
REQ-019 SHALL, on store or error, go directly to RESP with o_rsp_valid high from T+1 (LAT ignored).
REQ-020 SHALL, on accepted load, read word at addr[N+1:2] and assert o_rsp_valid from T+LAT; WAIT counts LAT-1 cycles (LAT=1 skips WAIT).
REQ-021 SHALL extract load byte at offset addr[1:0] or half at addr[1]; B/H sign-extend bit 7/15, BU/HU zero-extend, W unmodified.
REQ-022 SHALL hold o_rsp_valid, o_rdata, o_err stable in RESP until i_rsp_ready; return to IDLE the cycle after handshake.
REQ-023 SHALL not accept a new request in the handshake cycle (ready rises at T_handshake+1).
REQ-024 SHALL leave memory unchanged on error requests; load after store to same address returns new data.
REQ-025 SHALL drive o_err=0 and o_rdata=0 on store responses without error.

Reset
REQ-026 SHALL, when i_rst high at an edge, force IDLE, o_rsp_valid=0, o_rdata=0, o_err=0, latency counter 0.
REQ-027 SHALL drop any pending response on reset mid-operation; a store written before reset stays written.
REQ-028 SHALL not accept or write requests while i_rst is high; memory contents not reset.

Structure
REQ-029 SHALL place funct3 width constants and FSM state encoding in shared package mem_pkg.
REQ-030 SHALL place load extraction/extension in combinational sub-module lsu_load_align (inputs word, offset, width; output 32-bit result).
REQ-031 SHALL model storage as 2^N x 32 array with per-byte write enables, inferable as block RAM.

Verification
REQ-032 SHALL test SW 0x80FF7F01 at 0x10, then LB 0x10 -> 0x00000001, LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, LH 0x12 -> 0xFFFF80FF.
REQ-033 SHALL test SB 0xAA at 0x21 over word 0x00000000, LW 0x20 -> 0x0000AA00; SH 0xBEEF at 0x22 -> LW 0xBEEFAA00.
REQ-034 SHALL test LW 0x06 and SH 0x03 -> o_err=1 at T+1, o_rdata=0, LW 0x04 unchanged.
REQ-035 SHALL test LAT=4: load accepted T -> o_rsp_valid first at T+4; i_rsp_ready low 3 cycles -> response held, o_req_ready low throughout.
REQ-036 SHALL test i_rst asserted in WAIT -> next cycle o_rsp_valid=0, o_req_ready=1 after reset release, no stale response.
REQ-037 SHALL test addr 0x4010 with N=12 aliasing to 0x0010 (store then load returns same data).
